// File: rtl/trap_ctrl_pkg.sv
// trap_ctrl_pkg -- shared definitions for the machine-mode trap controller.
//
// Contents:
//   XLEN_DEFAULT        default data/PC width
//   state_e             controller FSM states (IDLE, TRAP_WR, MRET_WR, REDIRECT)
//   MSTATUS_* indices   MIE=3, MPIE=7, MPP=12:11
//   IRQ_CODE_*          interrupt cause codes (software 3, timer 7, external 11)
//   irq_code()          priority pick among enabled pending interrupts
package trap_ctrl_pkg;

    localparam int XLEN_DEFAULT = 32;

    // mstatus bit positions
    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    // Interrupt cause codes; they double as mip/mie bit positions
    localparam int IRQ_CODE_SW  = 3;
    localparam int IRQ_CODE_TMR = 7;
    localparam int IRQ_CODE_EXT = 11;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        TRAP_WR  = 2'd1,
        MRET_WR  = 2'd2,
        REDIRECT = 2'd3
    } state_e;

    // pend = {ext, tmr, sw}, already masked by mie. Priority is
    // external > software > timer.
    function automatic logic [3:0] irq_code(input logic [2:0] pend);
        logic [3:0] code;
        if (pend[2]) begin
            code = 4'(IRQ_CODE_EXT);
        end else if (pend[0]) begin
            code = 4'(IRQ_CODE_SW);
        end else begin
            code = 4'(IRQ_CODE_TMR);
        end
        return code;
    endfunction

endpackage

// File: rtl/trap_ctrl_if.sv
// trap_ctrl_if -- fetch redirect handshake between trap_ctrl and fetch.
//
// Signals:
//   redirect_valid_o  trap_ctrl -> fetch, a redirect target is offered
//   redirect_pc_o     trap_ctrl -> fetch, target PC
//   redirect_ready_i  fetch -> trap_ctrl, fetch takes the target
//
// Handshake: the transfer happens on a rising edge where valid and ready
// are both 1. Once valid is raised it stays high, and pc stays stable,
// until that edge; valid never depends on ready.
interface trap_ctrl_if
    import trap_ctrl_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
);
    logic            redirect_valid_o;
    logic            redirect_ready_i;
    logic [XLEN-1:0] redirect_pc_o;

    modport master (
        output redirect_valid_o,
        output redirect_pc_o,
        input  redirect_ready_i
    );

    modport slave (
        input  redirect_valid_o,
        input  redirect_pc_o,
        output redirect_ready_i
    );
endinterface

// File: rtl/trap_ctrl_irq_sync.sv
// irq_sync -- two-flop synchroniser, one chain per bit, for raw interrupt
// lines.
//
// Ports:
//   clk_i  clock
//   rst_i  asynchronous active-low reset, clears both stages
//   d_i    asynchronous input lines
//   q_o    synchronised lines (two cycles of latency)
module irq_sync #(
    parameter int W = 3
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);
    logic [W-1:0] meta;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            meta <= '0;
            q_o  <= '0;
        end else begin
            meta <= d_i;
            q_o  <= meta;
        end
    end
endmodule

// File: rtl/trap_ctrl.sv
// trap_ctrl -- machine-mode trap controller: accepts a synchronous
// exception, an MRET, or a pending interrupt, issues the CSR update bus
// for one cycle, then offers the new fetch target until fetch takes it.
//
// Build option: define TRAP_CTRL_VECTORED_EN to vector interrupts to
// base + 4*code when mtvec mode is 01. Without it every trap uses the base.
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-low reset
//   exc_valid_i/code/pc/tval synchronous exception request and operands
//   mret_i, cur_pc_i        MRET request, PC saved for an interrupt
//   irq_i                   raw {external, timer, software} lines
//   mstatus_i..mtval_i      current CSR contents
//   ack_o, flush_o          one-cycle pulse when an event is accepted
//   redir (master)          fetch redirect handshake
//   we_exc_o, is_int_o      CSR write strobe and interrupt flag
//   mcause_o..mip_o         CSR update values; mip_o is the live pending view
//   busy_o                  FSM not in IDLE
//   state_o                 FSM state, for observation
module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            exc_valid_i,
    input  logic [3:0]      exc_code_i,
    input  logic [XLEN-1:0] exc_pc_i,
    input  logic [XLEN-1:0] exc_tval_i,
    input  logic            mret_i,
    input  logic [XLEN-1:0] cur_pc_i,
    input  logic [2:0]      irq_i,
    input  logic [XLEN-1:0] mstatus_i,
    input  logic [XLEN-1:0] mie_i,
    input  logic [XLEN-1:0] mtvec_i,
    input  logic [XLEN-1:0] mepc_i,
    input  logic [XLEN-1:0] mcause_i,
    input  logic [XLEN-1:0] mtval_i,
    output logic            ack_o,
    output logic            flush_o,
    trap_ctrl_if.master     redir,
    output logic            we_exc_o,
    output logic            is_int_o,
    output logic [XLEN-1:0] mcause_o,
    output logic [XLEN-1:0] mepc_o,
    output logic [XLEN-1:0] mtval_o,
    output logic [XLEN-1:0] mstatus_o,
    output logic [XLEN-1:0] mip_o,
    output logic            busy_o,
    output state_e          state_o
);
    state_e          state, state_nx;
    logic [2:0]      irq_s;
    logic [XLEN-1:0] pend;
    logic            int_pending;
    logic [3:0]      int_code;
    logic            take_exc, take_mret, take_irq;

    // Operands captured at acceptance
    logic            is_int_q;
    logic [3:0]      code_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] tval_q;
    logic [XLEN-1:0] target_q;

    logic [XLEN-1:0] trap_base, trap_target;
    logic [XLEN-1:0] trap_status, mret_status;

    irq_sync #(.W(3)) u_irq_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (irq_i),
        .q_o   (irq_s)
    );

    always_comb begin
        mip_o               = '0;
        mip_o[IRQ_CODE_EXT] = irq_s[2];
        mip_o[IRQ_CODE_TMR] = irq_s[1];
        mip_o[IRQ_CODE_SW]  = irq_s[0];
    end

    assign pend        = mip_o & mie_i;
    assign int_pending = mstatus_i[MSTATUS_MIE] & (|pend);
    assign int_code    = irq_code({pend[IRQ_CODE_EXT], pend[IRQ_CODE_TMR], pend[IRQ_CODE_SW]});

    // mstatus after trap entry and after MRET
    always_comb begin
        trap_status                                = mstatus_i;
        trap_status[MSTATUS_MPIE]                  = mstatus_i[MSTATUS_MIE];
        trap_status[MSTATUS_MIE]                   = 1'b0;
        trap_status[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        mret_status                                = mstatus_i;
        mret_status[MSTATUS_MIE]                   = mstatus_i[MSTATUS_MPIE];
        mret_status[MSTATUS_MPIE]                  = 1'b1;
        mret_status[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    end

    assign trap_base = {mtvec_i[XLEN-1:2], 2'b00};

`ifdef TRAP_CTRL_VECTORED_EN
    assign trap_target = (is_int_q && (mtvec_i[1:0] == 2'b01))
                       ? trap_base + {{(XLEN-6){1'b0}}, code_q, 2'b00}
                       : trap_base;
`else
    // Mode bits have no effect in this build
    logic unused_mtvec_mode;
    assign unused_mtvec_mode = ^mtvec_i[1:0];
    assign trap_target       = trap_base;
`endif

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            is_int_q <= 1'b0;
            code_q   <= '0;
            pc_q     <= '0;
            tval_q   <= '0;
            target_q <= RESET_PC;
        end else begin
            if (take_exc) begin
                is_int_q <= 1'b0;
                code_q   <= exc_code_i;
                pc_q     <= exc_pc_i;
                tval_q   <= exc_tval_i;
            end else if (take_irq) begin
                is_int_q <= 1'b1;
                code_q   <= int_code;
                pc_q     <= cur_pc_i;
                tval_q   <= '0;
            end
            // Target is frozen on leaving the write state so it stays stable
            // for the whole redirect handshake.
            if (state == TRAP_WR) begin
                target_q <= trap_target;
            end else if (state == MRET_WR) begin
                target_q <= mepc_i;
            end
        end
    end

    always_comb begin
        state_nx               = state;
        take_exc               = 1'b0;
        take_mret              = 1'b0;
        take_irq               = 1'b0;
        we_exc_o               = 1'b0;
        is_int_o               = 1'b0;
        mepc_o                 = '0;
        mcause_o               = '0;
        mtval_o                = '0;
        mstatus_o              = '0;
        redir.redirect_valid_o = 1'b0;
        unique case (state)
            IDLE: begin
                if (exc_valid_i) begin
                    take_exc = 1'b1;
                    state_nx = TRAP_WR;
                end else if (mret_i) begin
                    take_mret = 1'b1;
                    state_nx  = MRET_WR;
                end else if (int_pending) begin
                    take_irq = 1'b1;
                    state_nx = TRAP_WR;
                end
            end
            TRAP_WR: begin
                we_exc_o  = 1'b1;
                is_int_o  = is_int_q;
                mepc_o    = pc_q;
                mcause_o  = is_int_q ? {1'b1, {(XLEN-5){1'b0}}, code_q}
                                     : {{(XLEN-4){1'b0}}, code_q};
                mtval_o   = tval_q;
                mstatus_o = trap_status;
                state_nx  = REDIRECT;
            end
            MRET_WR: begin
                we_exc_o  = 1'b1;
                mepc_o    = mepc_i;
                mcause_o  = mcause_i;
                mtval_o   = mtval_i;
                mstatus_o = mret_status;
                state_nx  = REDIRECT;
            end
            REDIRECT: begin
                redir.redirect_valid_o = 1'b1;
                if (redir.redirect_ready_i) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // The accept decode is combinational in IDLE; gating with reset keeps
    // the pulses low while reset is held even if a request is present.
    assign ack_o               = (take_exc | take_mret | take_irq) & rst_i;
    assign flush_o             = ack_o;
    assign redir.redirect_pc_o = target_q;
    assign busy_o              = (state != IDLE);
    assign state_o             = state;

endmodule

// File: doc/trap_ctrl.md
TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 32: width of all data/PC ports.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000: redirect_pc_o value held in reset.
REQ-003 SHALL have ports clk_i (in, 1, clock) and rst_i (in, 1, reset). One clock; reset is asynchronous and active-low.
REQ-004 SHALL have ports exc_valid_i (in, 1, sync exception pending), exc_code_i (in, 4, cause), exc_pc_i (in, XLEN, faulting PC) and exc_tval_i (in, XLEN, trap value).
REQ-005 SHALL have ports mret_i (in, 1, MRET retiring), cur_pc_i (in, XLEN, next-commit PC) and irq_i (in, 3, {external, timer, software} raw asynchronous lines).
REQ-006 SHALL have ports mstatus_i, mie_i, mtvec_i, mepc_i, mcause_i and mtval_i (in, XLEN each): current CSR contents.
REQ-007 SHALL have ports ack_o (out, 1, event accepted) and flush_o (out, 1, pipeline flush).
REQ-008 SHALL have ports redirect_valid_o (out, 1), redirect_ready_i (in, 1) and redirect_pc_o (out, XLEN): fetch redirect handshake.
REQ-009 SHALL have ports we_exc_o and is_int_o (out, 1 each), and mcause_o, mepc_o, mtval_o, mstatus_o, mip_o (out, XLEN each): CSR update bus.
REQ-010 SHALL have port busy_o (out, 1): FSM not in IDLE.

Function
REQ-011 SHALL synchronise irq_i through 2 flops; mip_o = {20'b0, ext, 3'b0, tmr, 3'b0, sw, 3'b0} (bits 11/7/3).
REQ-012 Interrupt pending SHALL be mstatus_i[3] & |(mip_o & mie_i); interrupt priority SHALL be 11 > 3 > 7.
REQ-013 FSM SHALL have states IDLE, TRAP_WR, MRET_WR and REDIRECT.
REQ-014 In IDLE SHALL accept exactly one event per cycle with priority exc_valid_i > mret_i > pending interrupt.
REQ-015 On acceptance ack_o and flush_o SHALL pulse 1 cycle; the FSM goes to TRAP_WR (exception/interrupt) or MRET_WR.
REQ-016 Inputs SHALL be ignored outside IDLE; the source holds exc_valid_i/mret_i until ack_o.
REQ-017 In TRAP_WR, we_exc_o=1 for 1 cycle with:
- mepc_o = exc_pc_i (exception) or cur_pc_i (interrupt)
- mcause_o = {28'b0, exc_code_i}, or {1'b1, 27'b0, irq code}
- mtval_o = exc_tval_i, or 0 for an interrupt
- mstatus_o = mstatus_i with MPIE<=MIE, MIE<=0, MPP<=2'b11
is_int_o SHALL be 1 in that cycle for an interrupt.
REQ-018 Event operands SHALL be registered at acceptance; TRAP_WR uses the registered copies.
REQ-019 In MRET_WR, we_exc_o=1 for 1 cycle with mepc_o=mepc_i, mcause_o=mcause_i, mtval_o=mtval_i, and mstatus_o: MIE<=MPIE, MPIE<=1, MPP<=2'b11.
REQ-020 Target SHALL be {mtvec_i[31:2], 2'b00} for a trap and mepc_i for MRET; the target is latched on leaving *_WR.
REQ-021 In REDIRECT, redirect_valid_o=1 with a stable redirect_pc_o until redirect_ready_i; on handshake the FSM returns to IDLE.
REQ-022 Latency SHALL be: accept at cycle N; we_exc_o at N+1; redirect_valid_o from N+2; next accept no earlier than the cycle after the handshake.
REQ-023 An exception that is simultaneous with an interrupt SHALL win; the interrupt remains pending and is taken on a later IDLE if still enabled.
REQ-024 If mstatus_i[3]=0, interrupts SHALL never be accepted, whatever the state of mip_o.

Reset
REQ-025 Async assertion SHALL force IDLE, including mid-operation, and clear sync flops and latched operands.
REQ-026 In reset, all 1-bit outputs SHALL be 0, all XLEN outputs 0, and redirect_pc_o = RESET_PC.
REQ-027 After deassertion, the first possible accept SHALL be the first rising edge.

Configuration
REQ-028 With TRAP_CTRL_VECTORED_EN defined, an interrupt with mtvec_i[1:0]==2'b01 SHALL target {mtvec_i[31:2],2'b00} + 4*code; exceptions always use the base.
REQ-029 Without TRAP_CTRL_VECTORED_EN, every trap SHALL target the base and mtvec_i[1:0] is ignored.

Structure
REQ-030 A shared package SHALL hold the FSM state enum, CSR bit indices (MIE=3, MPIE=7, MPP=12:11), interrupt codes (3, 7, 11) and the XLEN default.
REQ-031 One sub-module, irq_sync (2-flop per-bit synchroniser, async active-low reset), SHALL be instantiated for irq_i.

Verification
REQ-032 Exception: exc_valid_i=1, code=2, pc=0x100, tval=0xDEAD, mtvec_i=0x80, mstatus_i=0x8 -> ack_o at N; at N+1 mepc_o=0x100, mcause_o=2, mtval_o=0xDEAD, mstatus_o=0x1880; redirect_pc_o=0x80.
REQ-033 MRET: mret_i=1, mepc_i=0x104, mstatus_i=0x1880 -> mstatus_o=0x1888 at N+1, redirect_pc_o=0x104.
REQ-034 Timer interrupt: irq_i=3'b010, mie_i=0x80, mstatus_i=0x8, cur_pc_i=0x200 -> accept 2 cycles later; mcause_o=0x80000007, mepc_o=0x200, is_int_o=1.
REQ-035 Simultaneous exception and external IRQ -> exception serviced first, then the IRQ with mcause_o=0x8000000B; with the macro and mtvec_i=0x81, target=0xAC.
REQ-036 redirect_ready_i held 0 for 5 cycles -> redirect_valid_o and redirect_pc_o stable, busy_o=1, new exc_valid_i not acked.
REQ-037 rst_i low during TRAP_WR -> outputs 0 immediately, no we_exc_o pulse, IDLE after release.
